lcd1602_responder: RTL
======================

// Module: lcd1602_responder
// PURPOSE
// HD44780-compatible 16x2 character-LCD responder: the display end of the RS/RW/E/D[7:0] bus our LCD drivers initiate.
// Decodes instructions, keeps a 32-char DDRAM, address counter (AC), display-control flags and busy flag; answers bus reads.
// Sits in the bench as a checking model of the panel and in-system as a shadow display that feeds VGA/UART mirrors via rd_addr/rd_char.
// Fully synchronous to clk; bus pins are oversampled (clk >= 20x E rate).
// PARAMETERS
// BUSY_CYCLES   50   clk cycles busy after any accepted instruction or data write (except clear)
// CLEAR_CYCLES  100  clk cycles busy after clear-display, counted after the 32-cycle RAM fill
// PORTS
// clk          in   1  system clock
// rst          in   1  asynchronous, active-high reset
// lcd_e        in   1  enable strobe from driver
// lcd_rs       in   1  0 = instruction/status, 1 = data
// lcd_rw       in   1  0 = write, 1 = read
// lcd_d_in     in   8  bus data from driver
// lcd_d_out    out  8  bus data to driver (valid when lcd_d_oe)
// lcd_d_oe     out  1  drive enable for read cycles
// busy         out  1  busy flag (BF)
// ac           out  7  address counter
// disp_on      out  1  D flag;  cursor_on  out 1  C flag;  blink_on  out 1  B flag
// two_line     out  1  N flag from function set;  bus_8bit  out 1  DL flag
// rd_addr      in   5  display read index (0-15 line 1, 16-31 line 2)
// rd_char      out  8  DDRAM[rd_addr], combinational
// drop_strobe  out  1  1-cycle pulse: write arrived while busy, or data write to unmapped address
// BEHAVIOUR
// - Reset: state=FILL, fill idx=0, AC=0, I/D=1, disp_on/cursor_on/blink_on=0, two_line=0, bus_8bit=1, lcd_d_oe=0, lcd_d_out=0, drop_strobe=0.
//   busy=1 from reset (state != IDLE); DDRAM filled with 8'h20 over 32 cycles, then IDLE. No busy countdown after reset fill.
// - Sync: E, RS, RW, D each pass 2 flops; edges from synced E vs. one more delay. Falling edge of E = commit; rising edge with RW=1 = read.
// - States: FILL (write 8'h20 at idx, idx++, exit at idx=31) -> WAIT (if clear) or IDLE; WAIT (count down, busy=1) -> IDLE; IDLE (busy=0).
// - Write (RW=0) commits on E fall using RS/D sampled in same synced cycle. In FILL/WAIT: ignored, drop_strobe pulses.
// - Instruction decode (RS=0), priority by highest set bit:
//   1xxxxxxx set DDRAM addr: AC=D[6:0].   01xxxxxx set CGRAM addr: cgram_mode=1, AC unchanged, later data writes dropped.
//   001DNFxx DL,N stored (F ignored).      0001SRxx S=0: cursor move AC+-1 (R=1 inc) with wrap; S=1 display shift: no effect.
//   00001DCB flags stored.                 000001IS I/D stored, S ignored.   0000001x AC=0.
//   00000001 clear: AC=0, I/D=1 -> FILL then WAIT(CLEAR_CYCLES).   00000000 no-op, no busy.
//   Any DDRAM-addr or clear instruction sets cgram_mode=0. Every other accepted instruction -> WAIT(BUSY_CYCLES).
// - Data write (RS=1): AC mapped (0x00-0x0F -> idx AC, 0x40-0x4F -> idx 16+AC[3:0]) -> DDRAM[idx]=D; unmapped or cgram_mode -> dropped, drop_strobe.
//   AC steps by I/D in all cases; then WAIT(BUSY_CYCLES).
// - AC wrap (two-line map): inc 0x27->0x40, 0x67->0x00; dec 0x00->0x67, 0x40->0x27. Set-address values 0x28-0x3F,0x68-0x7F held as written.
// - Read (RW=1): on synced E rise lcd_d_oe=1, lcd_d_out = RS ? DDRAM[idx] (8'h20 if unmapped) : {busy, AC}; oe drops on E fall.
//   Data read steps AC by I/D on E fall and starts no busy period; status read never changes state. Reads allowed while busy.
// - Busy countdown loads N-1, busy falls on cycle N after the commit cycle. Simultaneous rd_addr read and DDRAM write: rd_char shows old value.
// - rst mid-FILL/WAIT: aborts, restarts reset fill; any partially synced E edge is discarded.
// TESTING
// - Reset, wait 32 clk -> busy=0, rd_char=8'h20 for all 32 idx, ac=0, disp_on=0.
// - Cmds 0x38,0x06,0x0C,0x01 then data "THIS" (each after busy=0) -> two_line=1, disp_on=1, cursor_on=0, rd_char[0..3]="THIS", ac=4.
// - 0x80|0x27, data 'A', data 'B' -> idx unchanged for 0x27 (drop_strobe), 'B' at idx 16, ac=0x41; 0x06->0x04, 0x80, data 'Z' -> ac=0x67.
// - Write 'X' then status read during busy -> lcd_d_out=8'h81 with oe=1; 2nd write before busy falls -> drop_strobe, DDRAM unchanged.
// - 0x01 after filling line 2 -> busy for 32+CLEAR_CYCLES cycles, all chars 8'h20, ac=0; data read at 0x40 via 0xC0 -> lcd_d_out=8'h20.
// - Assert rst 10 cycles into clear's WAIT -> all outputs at reset values, fill restarts, busy=0 after 32 cycles.

Source files
------------

// File: rtl/lcd1602_responder.sv
// lcd1602_responder
//   HD44780-compatible 16x2 character-LCD responder. Watches the RS/RW/E/D
//   bus driven by an LCD controller, decodes instructions, keeps a 32-entry
//   DDRAM, the address counter, the display-control flags and the busy flag,
//   and drives read data back onto the bus. A second, combinational read
//   port (rd_addr/rd_char) lets a display mirror scan the character buffer.
//
//   The bus pins are oversampled: everything runs on clk and the bus is
//   brought in through two-flop synchronizers.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   lcd_e/rs/rw         enable strobe, register select (1=data), read/write (1=read)
//   lcd_d_in            bus data from the driver
//   lcd_d_out, lcd_d_oe read data and its drive enable
//   busy                busy flag (high whenever the engine is not idle)
//   ac                  address counter
//   disp_on/cursor_on/blink_on, two_line, bus_8bit   stored control flags
//   rd_addr, rd_char    display scan port: 0-15 line 1, 16-31 line 2
//   drop_strobe         one-cycle pulse when a write is discarded
module lcd1602_responder #(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lcd_e,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_d_in,
    output logic [7:0] lcd_d_out,
    output logic       lcd_d_oe,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       bus_8bit,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic       drop_strobe
);

    localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_CYCLES) ? BUSY_CYCLES : CLEAR_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_WAIT = 2'd1,
        S_IDLE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Address-counter helpers (two-line DDRAM map)
    // ------------------------------------------------------------------
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            case (a)
                7'h27:   r = 7'h40;
                7'h67:   r = 7'h00;
                default: r = a + 7'd1;
            endcase
        end else begin
            case (a)
                7'h00:   r = 7'h67;
                7'h40:   r = 7'h27;
                default: r = a - 7'd1;
            endcase
        end
        return r;
    endfunction

    // Only the first 16 cells of each line exist in this buffer.
    function automatic logic ac_mapped(input logic [6:0] a);
        return (a[6:4] == 3'b000) || (a[6:4] == 3'b100);
    endfunction

    function automatic logic [4:0] ac_idx(input logic [6:0] a);
        return {a[6], a[3:0]};
    endfunction

    // ------------------------------------------------------------------
    // Bus synchronizers and E edge detect
    // ------------------------------------------------------------------
    logic [1:0] e_sy, rs_sy, rw_sy;
    logic [7:0] d_sy0, d_sy1;
    logic       e_dly;
    logic       e_rise, e_fall, rs_s, rw_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_sy  <= 2'b00;
            rs_sy <= 2'b00;
            rw_sy <= 2'b00;
            d_sy0 <= 8'h00;
            d_sy1 <= 8'h00;
            e_dly <= 1'b0;
        end else begin
            e_sy  <= {e_sy[0], lcd_e};
            rs_sy <= {rs_sy[0], lcd_rs};
            rw_sy <= {rw_sy[0], lcd_rw};
            d_sy0 <= lcd_d_in;
            d_sy1 <= d_sy0;
            e_dly <= e_sy[1];
        end
    end

    assign e_rise = e_sy[1] & ~e_dly;
    assign e_fall = ~e_sy[1] & e_dly;
    assign rs_s   = rs_sy[1];
    assign rw_s   = rw_sy[1];

    // ------------------------------------------------------------------
    // Character RAM: one write port, two combinational read ports
    // ------------------------------------------------------------------
    logic [7:0] ddram [32];
    logic       we;
    logic [4:0] waddr;
    logic [7:0] wdata;
    logic [7:0] bus_rd_data;

    always_ff @(posedge clk) begin
        if (we) ddram[waddr] <= wdata;
    end

    assign rd_char     = ddram[rd_addr];
    assign bus_rd_data = ac_mapped(ac) ? ddram[ac_idx(ac)] : 8'h20;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t        state, state_n;
    logic [4:0]    fill_idx, fill_idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          clr_pend, clr_pend_n;   // fill was started by clear: wait afterwards
    logic [6:0]    ac_n;
    logic          inc_dec, inc_dec_n;
    logic          cgram_mode, cgram_n;    // AC points into CGRAM: data writes discarded
    logic          disp_n, cur_n, blink_n, two_n, dl_n;
    logic          oe_n, drop_n;
    logic [7:0]    dout_n;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FILL;
            fill_idx    <= 5'd0;
            cnt         <= '0;
            clr_pend    <= 1'b0;
            ac          <= 7'h00;
            inc_dec     <= 1'b1;
            cgram_mode  <= 1'b0;
            disp_on     <= 1'b0;
            cursor_on   <= 1'b0;
            blink_on    <= 1'b0;
            two_line    <= 1'b0;
            bus_8bit    <= 1'b1;
            lcd_d_oe    <= 1'b0;
            lcd_d_out   <= 8'h00;
            drop_strobe <= 1'b0;
        end else begin
            state       <= state_n;
            fill_idx    <= fill_idx_n;
            cnt         <= cnt_n;
            clr_pend    <= clr_pend_n;
            ac          <= ac_n;
            inc_dec     <= inc_dec_n;
            cgram_mode  <= cgram_n;
            disp_on     <= disp_n;
            cursor_on   <= cur_n;
            blink_on    <= blink_n;
            two_line    <= two_n;
            bus_8bit    <= dl_n;
            lcd_d_oe    <= oe_n;
            lcd_d_out   <= dout_n;
            drop_strobe <= drop_n;
        end
    end

    always_comb begin
        state_n    = state;
        fill_idx_n = fill_idx;
        cnt_n      = cnt;
        clr_pend_n = clr_pend;
        ac_n       = ac;
        inc_dec_n  = inc_dec;
        cgram_n    = cgram_mode;
        disp_n     = disp_on;
        cur_n      = cursor_on;
        blink_n    = blink_on;
        two_n      = two_line;
        dl_n       = bus_8bit;
        oe_n       = lcd_d_oe;
        dout_n     = lcd_d_out;
        drop_n     = 1'b0;
        we         = 1'b0;
        waddr      = fill_idx;
        wdata      = 8'h20;

        // Background engine: RAM fill and busy countdown
        case (state)
            S_FILL: begin
                we         = 1'b1;
                fill_idx_n = fill_idx + 5'd1;
                if (fill_idx == 5'd31) begin
                    if (clr_pend) begin
                        state_n    = S_WAIT;
                        cnt_n      = CW'(CLEAR_CYCLES - 1);
                        clr_pend_n = 1'b0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) state_n = S_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: ;
        endcase

        // Read cycle: drive data from the rising edge of E
        if (e_rise && rw_s) begin
            oe_n   = 1'b1;
            dout_n = rs_s ? bus_rd_data : {busy, ac};
        end

        // Falling edge of E commits the cycle
        if (e_fall) begin
            oe_n = 1'b0;
            if (rw_s) begin
                if (rs_s) ac_n = ac_step(ac, inc_dec);
            end else if (state != S_IDLE) begin
                drop_n = 1'b1;
            end else if (rs_s) begin
                if (ac_mapped(ac) && !cgram_mode) begin
                    we    = 1'b1;
                    waddr = ac_idx(ac);
                    wdata = d_sy1;
                end else begin
                    drop_n = 1'b1;
                end
                ac_n    = ac_step(ac, inc_dec);
                state_n = S_WAIT;
                cnt_n   = CW'(BUSY_CYCLES - 1);
            end else begin
                // Instruction: the highest set bit selects the command
                state_n = S_WAIT;
                cnt_n   = CW'(BUSY_CYCLES - 1);
                priority casez (d_sy1)
                    8'b1???????: begin
                        ac_n    = d_sy1[6:0];
                        cgram_n = 1'b0;
                    end
                    8'b01??????: cgram_n = 1'b1;
                    8'b001?????: begin
                        dl_n  = d_sy1[4];
                        two_n = d_sy1[3];
                    end
                    8'b0001????: begin
                        // Display shift has no visible effect on a shadow buffer
                        if (!d_sy1[3]) ac_n = ac_step(ac, d_sy1[2]);
                    end
                    8'b00001???: begin
                        disp_n  = d_sy1[2];
                        cur_n   = d_sy1[1];
                        blink_n = d_sy1[0];
                    end
                    8'b000001??: inc_dec_n = d_sy1[1];
                    8'b0000001?: ac_n = 7'h00;
                    8'b00000001: begin
                        ac_n       = 7'h00;
                        inc_dec_n  = 1'b1;
                        cgram_n    = 1'b0;
                        state_n    = S_FILL;
                        fill_idx_n = 5'd0;
                        clr_pend_n = 1'b1;
                    end
                    default: begin
                        state_n = state;
                        cnt_n   = cnt;
                    end
                endcase
            end
        end
    end

endmodule
